sd_route_ctl: RTL
=================

# sd_route_ctl

Parametrised SD/SPI routing controller sitting between the core's single SPI master and NCH virtual SD image back-ends plus the physical SD slot. It selects the active back-end from image mount events and defers switching until the bus is idle. It issues a retriggerable core reset pulse on every route change and drives separate activity indicators for the virtual and physical paths. Successor to the fixed one-image SD select/activity logic in the top level.

## Interface
Parameters:
- NCH, 2: number of virtual image slots (1..8).
- ACT_TIMEOUT, 1000000: activity hold time in clk_sys cycles.
- RST_PULSE, 10000000: reset pulse length in clk_sys cycles.
- SELW, $clog2(NCH+1): width of route code.

Ports:
- clk_sys  in  1  system clock; sole clock.
- reset_n  in  1  synchronous, active-low reset.
- img_mounted  in  NCH  one-cycle mount strobe per slot.
- img_nz  in  NCH  image size non-zero, valid with strobe.
- spi_sck, spi_mosi, spi_ss  in  1 each  core SPI master (ss active low).
- spi_miso  out  1  MISO back to core.
- vsd_ss  out  NCH  per-slot virtual chip select (active low).
- vsd_miso  in  NCH  per-slot virtual MISO.
- phy_cs, phy_sck, phy_mosi  out  1 each  physical slot pins.
- phy_miso  in  1  physical MISO.
- route  out  SELW  0 = physical, k = virtual slot k-1.
- img_reset  out  1  core cold-reset request.
- act_virt, act_phy  out  1 each  activity indicators.

## Operation
- Route request: on a cycle with any img_mounted bit set, lowest set index i wins. If img_nz[i]=1, the request is i+1. If img_nz[i]=0 and route==i+1, the request is 0. Otherwise no request.
- A pending request is held in a 1-deep register. A newer request overwrites it.
- Commit: a pending request commits to route only on a cycle where spi_ss==1, which is never mid-transaction. Commit clears pending.
- If the committed value equals the current route, no change and no pulse.
- Reset pulse: every route change loads the pulse counter with RST_PULSE-1 and sets img_reset=1. img_reset stays 1 until the counter reaches 0. A change during the pulse reloads the counter (retrigger).
- Muxing is combinational:
  - spi_miso = route ? vsd_miso[route-1] : phy_miso.
  - vsd_ss[k] = spi_ss | (route != k+1).
  - phy_cs = spi_ss | (route != 0).
  - phy_sck = spi_sck & ~phy_cs; phy_mosi = spi_mosi & ~phy_cs.
- Activity: mosi and the muxed miso are registered once. Any toggle reloads an activity counter to 0. The counter increments while < ACT_TIMEOUT and saturates there. act is 1 while counter < ACT_TIMEOUT.
  - The toggle feeds the virtual counter if route!=0, else the physical counter. The idle counter is not touched.
- Width rule: counters are $clog2(max(ACT_TIMEOUT,RST_PULSE)+1) bits, unsigned, no wrap.

## Timing
- Reset (reset_n=0 at clock edge):
  - route=0, pending cleared, img_reset=0.
  - Activity counters = ACT_TIMEOUT, so act_virt=act_phy=0.
  - Reset wins over a simultaneous mount strobe.
- Mount strobe at cycle t with spi_ss=1: pending set at t+1, route and img_reset update at t+2.
- With spi_ss=0, commit waits for the first edge with spi_ss=1 sampled.
- SPI mux latency: 0 cycles. Activity latency: toggle at t gives act=1 from t+2.
- act drops exactly ACT_TIMEOUT cycles after the last reload.
- img_reset width is exactly RST_PULSE cycles from last load.

## Structure
- Package sd_route_pkg:
  - ROUTE_PHY = 0 constant.
  - Function route_of(slot) = slot+1.
  - Counter width function.
- Sub-module retrig_timer: load, count, saturate, busy flag. Instantiated three times: reset pulse, virtual activity, physical activity.
- Top block holds request arbitration, pending/commit register and combinational mux.

## Test plan
- Reset, then mount slot 1 nz=1 with ss=1 -> route=2 two cycles later; img_reset high exactly RST_PULSE (set 20) cycles; vsd_ss[1] follows spi_ss; phy_cs=1.
- Mount slot 0 during ss=0 transfer -> route unchanged until ss rises, then route=1; no glitch on spi_miso mid-transfer.
- Simultaneous strobes on slots 0 and 1 -> route=1. Then slot 0 nz=0 -> route=0, second pulse.
- Remount same slot (route=1, slot 0 nz=1) -> no route change, img_reset stays 0. Change again at pulse cycle 10 of 20 -> img_reset lasts 30 cycles total.
- Toggle mosi once, route=0, ACT_TIMEOUT=8 -> act_phy high cycles t+2..t+9, act_virt stays 0.
- Assert reset_n=0 mid-pulse and mid-pending -> all outputs to reset values next edge; the pending request is discarded.

Source files
------------

// File: rtl/sd_route_pkg.sv
// Shared constants and helpers for the SD/SPI routing controller.
package sd_route_pkg;

    // Route code 0 selects the physical SD slot.
    localparam int unsigned ROUTE_PHY = 0;

    // Route code used for virtual image slot 'slot'.
    function automatic int unsigned route_of(input int unsigned slot);
        return slot + 1;
    endfunction

    // Bits needed to hold the larger of two counter limits without wrapping.
    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
        int unsigned m;
        m = (a > b) ? a : b;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/sd_route_ctl_retrig_timer.sv
// Retriggerable saturating timer: a load restarts the count at zero and
// busy_o stays high for exactly LIMIT cycles after the most recent load.
module retrig_timer #(
    parameter int unsigned CW    = 8,
    parameter int unsigned LIMIT = 8
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic load_i,
    output logic busy_o
);

    localparam logic [CW-1:0] LIM = CW'(LIMIT);

    logic [CW-1:0] cnt_q, cnt_d;

    // Restart on load, otherwise count up and saturate at the limit.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = '0;
        end else if (cnt_q < LIM) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Reset parks the counter at the limit so the timer starts idle.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= LIM;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign busy_o = (cnt_q < LIM);

endmodule

// File: rtl/sd_route_ctl.sv
// SD/SPI routing controller: picks the physical slot or one of NCH virtual
// image back-ends, defers route switches until the SPI bus is idle, raises a
// retriggerable core reset on each route change and drives activity LEDs.
module sd_route_ctl
    import sd_route_pkg::*;
#(
    parameter int unsigned NCH         = 2,
    parameter int unsigned ACT_TIMEOUT = 1000000,
    parameter int unsigned RST_PULSE   = 10000000,
    parameter int unsigned SELW        = $clog2(NCH + 1)
) (
    input  logic            clk_sys,
    input  logic            reset_n,
    input  logic [NCH-1:0]  img_mounted,
    input  logic [NCH-1:0]  img_nz,
    input  logic            spi_sck,
    input  logic            spi_mosi,
    input  logic            spi_ss,
    output logic            spi_miso,
    output logic [NCH-1:0]  vsd_ss,
    input  logic [NCH-1:0]  vsd_miso,
    output logic            phy_cs,
    output logic            phy_sck,
    output logic            phy_mosi,
    input  logic            phy_miso,
    output logic [SELW-1:0] route,
    output logic            img_reset,
    output logic            act_virt,
    output logic            act_phy
);

    localparam int unsigned     CW   = cnt_width(ACT_TIMEOUT, RST_PULSE);
    localparam logic [SELW-1:0] RPHY = SELW'(ROUTE_PHY);

    logic [SELW-1:0] route_q, route_d;
    logic [SELW-1:0] pend_q, pend_d;
    logic            pend_v_q, pend_v_d;

    logic            hit, hit_nz;
    logic [SELW-1:0] hit_route;
    logic            req_v;
    logic [SELW-1:0] req_route;
    logic            commit, change;

    logic            mosi_q, mosi_qq, miso_q, miso_qq;
    logic            toggle;

    // Lowest strobed slot wins; a zero-size image only unroutes its own slot.
    always_comb begin
        hit       = 1'b0;
        hit_nz    = 1'b0;
        hit_route = RPHY;
        for (int unsigned k = 0; k < NCH; k++) begin
            if (img_mounted[k] && !hit) begin
                hit       = 1'b1;
                hit_nz    = img_nz[k];
                hit_route = SELW'(route_of(k));
            end
        end
        req_v     = 1'b0;
        req_route = RPHY;
        if (hit) begin
            if (hit_nz) begin
                req_v     = 1'b1;
                req_route = hit_route;
            end else if (route_q == hit_route) begin
                req_v     = 1'b1;
                req_route = RPHY;
            end
        end
    end

    // Pending request commits only while chip select is deasserted; a new
    // request in the same cycle as a commit stays pending for the next one.
    always_comb begin
        commit   = pend_v_q & spi_ss;
        change   = commit && (pend_q != route_q);
        route_d  = commit ? pend_q : route_q;
        pend_d   = pend_q;
        pend_v_d = pend_v_q;
        if (req_v) begin
            pend_d   = req_route;
            pend_v_d = 1'b1;
        end else if (commit) begin
            pend_v_d = 1'b0;
        end
    end

    // Route and pending-request registers.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            route_q  <= RPHY;
            pend_q   <= RPHY;
            pend_v_q <= 1'b0;
        end else begin
            route_q  <= route_d;
            pend_q   <= pend_d;
            pend_v_q <= pend_v_d;
        end
    end

    // Zero-latency SPI steering toward the selected back-end.
    always_comb begin
        spi_miso = phy_miso;
        vsd_ss   = '1;
        for (int unsigned k = 0; k < NCH; k++) begin
            if (route_q == SELW'(route_of(k))) begin
                spi_miso = vsd_miso[k];
            end
            vsd_ss[k] = spi_ss | (route_q != SELW'(route_of(k)));
        end
        phy_cs   = spi_ss | (route_q != RPHY);
        phy_sck  = spi_sck & ~phy_cs;
        phy_mosi = spi_mosi & ~phy_cs;
    end

    // Sample MOSI and the muxed MISO; a change between samples is activity.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            mosi_q  <= 1'b0;
            mosi_qq <= 1'b0;
            miso_q  <= 1'b0;
            miso_qq <= 1'b0;
        end else begin
            mosi_q  <= spi_mosi;
            mosi_qq <= mosi_q;
            miso_q  <= spi_miso;
            miso_qq <= miso_q;
        end
    end

    assign toggle = (mosi_q ^ mosi_qq) | (miso_q ^ miso_qq);

    // Counting up from zero to RST_PULSE gives the same RST_PULSE-cycle pulse
    // as loading RST_PULSE-1 and holding until the down-count reaches zero.
    retrig_timer #(
        .CW    (CW),
        .LIMIT (RST_PULSE)
    ) u_rst_pulse (
        .clk_i  (clk_sys),
        .rst_ni (reset_n),
        .load_i (change),
        .busy_o (img_reset)
    );

    retrig_timer #(
        .CW    (CW),
        .LIMIT (ACT_TIMEOUT)
    ) u_act_virt (
        .clk_i  (clk_sys),
        .rst_ni (reset_n),
        .load_i (toggle & (route_q != RPHY)),
        .busy_o (act_virt)
    );

    retrig_timer #(
        .CW    (CW),
        .LIMIT (ACT_TIMEOUT)
    ) u_act_phy (
        .clk_i  (clk_sys),
        .rst_ni (reset_n),
        .load_i (toggle & (route_q == RPHY)),
        .busy_o (act_phy)
    );

    assign route = route_q;

endmodule
